// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Front end for a 4x4 active-low matrix keypad. One column at a time is driven
// low. The row returns are synchronised and debounced, and the accepted key is
// encoded as a hex nibble. Downstream logic consumes `key` when `released`
// strobes, so a key value is committed only once the key has been let go.
//
// Parameters:
//   SCAN_DIV        clk cycles each column stays driven. Rows are sampled once,
//                   on the last cycle of the slot. Minimum 4.
//   DEBOUNCE        consecutive matching samples needed to accept a press or a
//                   release. Minimum 2.
//   REPEAT_SAMPLES  held samples between auto-repeat strobes. Used only when
//                   KEYPAD_AUTOREPEAT_EN is defined.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-low reset
//   row[3:0]  in   keypad row returns. Asynchronous, active-low, pulled up.
//   col[3:0]  out  column drive. Active-low, at most one bit low.
//   key[3:0]  out  code of the last accepted key, row_idx*4 + col_idx
//   pressed   out  level. A debounced key is currently held.
//   released  out  one-cycle strobe. `key` is valid and final.
//
// Optional feature:
//   KEYPAD_AUTOREPEAT_EN  When defined, a held key strobes `released` every
//                         REPEAT_SAMPLES held samples while `pressed` stays
//                         high. When undefined, no repeat logic is built.
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE       = 4,
  parameter int REPEAT_SAMPLES = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       pressed,
  output logic       released
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE < 2) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE must be at least 2");
  end
  if (REPEAT_SAMPLES < 1) begin : g_bad_repeat
    $error("keypad_scanner: REPEAT_SAMPLES must be at least 1");
  end

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]        row_meta;   // first synchroniser stage
  logic [3:0]        rs;         // synchronised rows, used for all decisions
  logic [SLOT_W-1:0] slot_cnt;
  logic [CNT_W-1:0]  cnt;        // debounce counter, shared by press and release
  logic [1:0]        col_idx;
  logic [1:0]        cand_row;   // row captured when the press was first seen
  logic              rpt_pulse;  // auto-repeat strobe (constant 0 when not built)

  logic              sample;
  logic              hit;
  logic [1:0]        hit_row;
  logic              same_row;
  logic              rel_sample;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_done;

  // ---------------------------------------------------------------------------
  // Row synchroniser. Idle rows read as all ones, so the flops reset to 1111
  // and no phantom press appears right after reset.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that each
  // flop samples the pre-edge value of its source; with blocking assignments
  // row_meta would fall straight through into rs in a single cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_meta <= 4'b1111;
      rs       <= 4'b1111;
    end else begin
      row_meta <= row;
      rs       <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample point and row decode
  // ---------------------------------------------------------------------------
  assign sample = (slot_cnt == SLOT_W'(SCAN_DIV - 1));

  // Lowest-numbered active row wins when several keys in one column are down.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    hit     = (rs != 4'b1111);
    hit_row = 2'd0;
    if (!rs[0]) begin
      hit_row = 2'd0;
    end else if (!rs[1]) begin
      hit_row = 2'd1;
    end else if (!rs[2]) begin
      hit_row = 2'd2;
    end else if (!rs[3]) begin
      hit_row = 2'd3;
    end
  end

  // While a key is tracked only its own row matters; other rows are ignored.
  assign same_row   = hit && (hit_row == cand_row);
  assign rel_sample = rs[cand_row];
  assign cnt_inc    = cnt + 1'b1;
  assign cnt_done   = (cnt_inc == CNT_W'(DEBOUNCE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_SCAN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. All decisions except leaving RELEASE happen on the
  // sample cycle only.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_SCAN: begin
        if (sample && hit) begin
          state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (sample) begin
          if (!same_row) begin
            state_nxt = ST_SCAN;
          end else if (cnt_done) begin
            state_nxt = ST_HELD;
          end
        end
      end
      ST_HELD: begin
        if (sample && rel_sample && cnt_done) begin
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_nxt = ST_SCAN;
      end
      default: begin
        state_nxt = ST_SCAN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. `pressed` drops in RELEASE, the same cycle `released` rises.
  // ---------------------------------------------------------------------------
  always_comb begin
    col      = ~(4'b0001 << col_idx);
    pressed  = (state == ST_HELD);
    released = (state == ST_RELEASE) || rpt_pulse;
  end

  // ---------------------------------------------------------------------------
  // Datapath: slot counter, column index, debounce counter, captured key.
  // The column only moves after a sample in SCAN, after a failed debounce, or
  // when leaving RELEASE; from DEBOUNCE through RELEASE it is frozen, which is
  // why keys in other columns are invisible during that time.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt <= '0;
      cnt      <= '0;
      col_idx  <= 2'd0;
      cand_row <= 2'd0;
      key      <= 4'd0;
    end else begin
      // RELEASE restarts the slot so the next column gets a full dwell time.
      if (sample || state == ST_RELEASE) begin
        slot_cnt <= '0;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      unique case (state)
        ST_SCAN: begin
          if (sample) begin
            if (hit) begin
              cand_row <= hit_row;
              cnt      <= CNT_W'(1);
            end else begin
              col_idx  <= col_idx + 1'b1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (sample) begin
            if (!same_row) begin
              cnt     <= '0;
              col_idx <= col_idx + 1'b1;
            end else if (cnt_done) begin
              key     <= {cand_row, col_idx};
              cnt     <= '0;
            end else begin
              cnt     <= cnt_inc;
            end
          end
        end
        ST_HELD: begin
          // A pressed sample restarts the release count, so a short bounce
          // never reaches DEBOUNCE and never strobes.
          if (sample) begin
            if (rel_sample) begin
              cnt <= cnt_inc;
            end else begin
              cnt <= '0;
            end
          end
        end
        ST_RELEASE: begin
          cnt     <= '0;
          col_idx <= col_idx + 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat
  // ---------------------------------------------------------------------------
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SAMPLES + 1);

  logic [REP_W-1:0] rpt_cnt;

  // Counts consecutive held samples in HELD. The strobe is raised on the
  // cycle after a held sample, so it can never coincide with entry into
  // RELEASE (which follows a released sample) or with the pressed rise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_pulse <= 1'b0;
    end else begin
      rpt_pulse <= 1'b0;
      if (state != ST_HELD) begin
        rpt_cnt <= '0;
      end else if (sample) begin
        if (rel_sample) begin
          rpt_cnt <= '0;
        end else if (rpt_cnt + 1'b1 == REP_W'(REPEAT_SAMPLES)) begin
          rpt_cnt   <= '0;
          rpt_pulse <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign rpt_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3,
// REPEAT_SAMPLES=5. A small keypad model turns a 16-bit "keys held" vector
// and the DUT's column drive into row returns; a force path injects raw row
// glitches. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE       = 3;
  localparam int REPEAT_SAMPLES = 5;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_PULSES = 2;
  localparam int RPT_FIRST  = 20;
  localparam int RPT_SECOND = 40;
`else
  localparam int RPT_PULSES = 0;
  localparam int RPT_FIRST  = -1;
  localparam int RPT_SECOND = -1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       pressed;
  logic       released;

  logic [15:0] keys = '0;       // bit r*4+c set: key at row r, column c held
  logic        force_en = 1'b0;
  logic [3:0]  row_force = 4'b1111;
  logic [3:0]  row_matrix;

  int n_vec  = 0;
  int n_err  = 0;
  int n_viol = 0;
  logic prev_rel = 1'b0;
  logic prev_pr  = 1'b0;

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low while its column is driven.
  always_comb begin
    row_matrix = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col[c]) row_matrix[r] = 1'b0;
      end
    end
  end

  assign row = force_en ? row_force : row_matrix;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE      (DEBOUNCE),
    .REPEAT_SAMPLES(REPEAT_SAMPLES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .row     (row),
    .col     (col),
    .key     (key),
    .pressed (pressed),
    .released(released)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cycle, sampled on the falling edge. Also tracks strobe rules:
  // no back-to-back `released`, no `released` on a `pressed` rise.
  task automatic tick();
    @(negedge clk);
    if (released && prev_rel) n_viol++;
    if (released && pressed && !prev_pr) n_viol++;
    prev_rel = released;
    prev_pr  = pressed;
  endtask

  // Wait for col to newly become `target` (first cycle of that slot).
  task automatic wait_col(input logic [3:0] target, input string tag);
    logic [3:0] prev;
    bit found;
    prev  = col;
    found = 0;
    for (int n = 0; n < 200 && !found; n++) begin
      tick();
      if (col == target && prev != target) found = 1;
      prev = col;
    end
    check({tag, "_reached"}, found, 1);
  endtask

  task automatic wait_pressed(input string tag, output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (pressed) found = 1;
    end
    check({tag, "_pressed_seen"}, found, 1);
  endtask

  task automatic wait_released(input string tag, output int n);
    bit found;
    found = 0;
    n = 0;
    while (!found && n < 200) begin
      tick();
      n++;
      if (released) found = 1;
    end
    check({tag, "_released_seen"}, found, 1);
  endtask

  initial begin
    int n;
    int cnt_a;
    int cnt_b;
    int off_a;
    int off_b;
    int off_c;
    int key_at;

    // ---------------- Reset and idle ----------------
    repeat (3) tick();
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 0);
    check("rst_pressed", pressed, 0);
    check("rst_released", released, 0);
    reset = 1'b1;
    cnt_a = 0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick();
      check($sformatf("idle_col_%0d", i), col, ~(4'b0001 << ((i / 4) % 4)) & 4'hF);
      if (released) cnt_a++;
    end
    check("idle_released_cnt", cnt_a, 0);
    check("idle_key", key, 0);
    check("idle_pressed", pressed, 0);

    // ---------------- Clean press/release, row 1 / column 2 ----------------
    keys[6] = 1'b1;
    wait_col(4'b1011, "p6_col2");
    wait_pressed("p6", n);
    check("p6_press_latency", n, 12);
    check("p6_key", key, 6);
    check("p6_col_frozen", col, 4'b1011);
    repeat (8) tick();
    check("p6_still_pressed", pressed, 1);
    check("p6_col_held", col, 4'b1011);
    keys[6] = 1'b0;
    wait_released("p6", n);
    check("p6_release_latency", n, 12);
    check("p6_pressed_low_on_strobe", pressed, 0);
    check("p6_key_on_strobe", key, 6);
    tick();
    check("p6_strobe_one_cycle", released, 0);
    check("p6_resume_col3", col, 4'b0111);
    check("p6_key_after", key, 6);

    // ---------------- Short glitch, row 3 / column 0 ----------------
    wait_col(4'b1110, "gl_col0");
    row_force = 4'b0111;
    force_en  = 1'b1;
    cnt_a = 0;
    for (int i = 1; i <= 28; i++) begin
      tick();
      if (pressed || released) cnt_a++;
      if (i == 4) begin
        check("gl_col_frozen", col, 4'b1110);
        force_en = 1'b0;
      end
      if (i == 7) check("gl_col_still_frozen", col, 4'b1110);
      if (i == 8) check("gl_col_advanced", col, 4'b1101);
    end
    check("gl_no_press", cnt_a, 0);
    check("gl_key_unchanged", key, 6);

    // ---------------- Release bounce, key F ----------------
    keys[15] = 1'b1;
    wait_pressed("kf", n);
    check("kf_key", key, 15);
    check("kf_col", col, 4'b0111);
    keys[15] = 1'b0;          // two released samples
    cnt_a  = 0;
    off_a  = -1;
    key_at = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (released) begin
        cnt_a++;
        if (off_a < 0) begin
          off_a  = i;
          key_at = key;
        end
      end
      if (i == 8)  keys[15] = 1'b1;   // one pressed sample
      if (i == 12) keys[15] = 1'b0;   // then released for good
    end
    check("kf_strobe_count", cnt_a, 1);
    check("kf_strobe_offset", off_a, 24);
    check("kf_key_on_strobe", key_at, 15);

    // ---------------- Two rows in one column ----------------
    keys[0] = 1'b1;
    keys[8] = 1'b1;
    wait_pressed("tr", n);
    check("tr_key_lowest_row", key, 0);
    check("tr_col", col, 4'b1110);
    keys = '0;
    wait_released("tr", n);
    check("tr_key_on_strobe", key, 0);

    // ---------------- Hold key 5 for 16 samples ----------------
    keys[5] = 1'b1;
    wait_pressed("ar", n);
    check("ar_key", key, 5);
    cnt_a  = 0;   // strobes while held
    cnt_b  = 0;   // cycles with pressed low while held
    off_a  = -1;
    off_b  = -1;
    off_c  = -1;
    key_at = -1;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i <= 52) begin
        if (!pressed) cnt_b++;
        if (released) begin
          cnt_a++;
          if (cnt_a == 1) off_a = i;
          if (cnt_a == 2) off_b = i;
        end
      end else if (released && off_c < 0) begin
        off_c  = i;
        key_at = key;
      end
      if (i == 52) keys[5] = 1'b0;
    end
    check("ar_pressed_held", cnt_b, 0);
    check("ar_repeat_count", cnt_a, RPT_PULSES);
    check("ar_repeat_first", off_a, RPT_FIRST);
    check("ar_repeat_second", off_b, RPT_SECOND);
    check("ar_release_offset", off_c, 64);
    check("ar_key_on_release", key_at, 5);

    // ---------------- Reset mid-press ----------------
    keys[10] = 1'b1;
    wait_pressed("rp", n);
    check("rp_key", key, 10);
    reset = 1'b0;
    tick();
    check("rp_pressed_cleared", pressed, 0);
    check("rp_key_cleared", key, 0);
    check("rp_col_restart", col, 4'b1110);
    check("rp_no_strobe", released, 0);
    repeat (2) tick();
    keys  = '0;
    reset = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (released || pressed) cnt_a++;
    end
    check("rp_quiet_after_reset", cnt_a, 0);

    check("strobe_rules", n_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
